interp_sched: RTL
=================

Name: interp_sched

Overview:
Sequencing controller for the interpolator chain: firQ feeding the zero-cross detector.
- Accepts low-rate 32-bit samples on a valid/ready handshake.
- Drives firQ at L times the input rate by zero-stuffing: one real sample followed by L-1 zeros.
- Frames the zero-cross detector output into fixed windows of FRAME filter outputs and reports the crossing count per window.
- Sits between the sample source and the top-level firQ/zero_cross pair.

Parameters:
L, 8, interpolation factor (>=1); number of fir_en strobes per accepted sample
DW, 32, input sample width
FRAC, 16, zero fraction bits appended to the sample on fir_data
FRAME, 256, fir_en strobes per measurement window (>=2)
CW, 9, width of the crossing counter and zc_count

Ports:
clk  in  1  clock; everything on the rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run control; sampled each cycle
in_valid  in  1  source has a sample
in_data  in  DW  signed input sample
in_ready  out  1  controller accepts a sample this cycle
fir_en  out  1  one filter-input strobe to firQ
fir_data  out  DW+FRAC  firQ input: {sample, FRAC'b0} or all-zero
zc_flag  in  1  crossing pulse from zero_cross
frame_done  out  1  one-cycle pulse; zc_count updated this cycle
zc_count  out  CW  crossings counted in the last completed frame

Behaviour:
- Reset values: in_ready=0 during reset, state IDLE, phase=0, fir_en=0, fir_data=0, frame_done=0, zc_count=0, frame counter=0, crossing accumulator=0.
- States:
  - IDLE: fir_en=0.
  - PUSH: fir_en=1, fir_data={held sample, FRAC'b0}.
  - STUFF: fir_en=1, fir_data=0.
- in_ready (combinational) = enable && (state==IDLE || (state==STUFF && phase==L-1) || (L==1 && state==PUSH)).
- Accept = in_valid && in_ready. The sample is registered and the next state is PUSH, with phase=0.
- PUSH transition: if L==1, go to PUSH on accept, otherwise IDLE. If L>1, go to STUFF with phase=1.
- STUFF transition: phase increments each cycle. At phase==L-1, go to PUSH on accept, otherwise IDLE.
- Latency: sample accepted at cycle t produces fir_en at t+1..t+L, with the real sample at t+1. Sustained throughput is one sample per L cycles with no bubbles.
- fir_data holds its value when fir_en=0.
- enable deassert:
  - Blocks new accepts only.
  - A burst in progress always completes all L strobes; no truncation.
  - Frame counters hold while idle.
- Frame counter: increments on each fir_en. On the fir_en that makes the count FRAME:
  - counter wraps to 0;
  - frame_done pulses the next cycle;
  - zc_count loads the accumulator value including any zc_flag in that same final cycle.
- Crossing accumulator:
  - +1 on every zc_flag cycle; saturates at 2^CW-1.
  - Cleared in the cycle the frame closes.
  - A zc_flag arriving in the cycle frame_done is asserted belongs to the new frame, so the accumulator restarts at 1.
- zc_flag is counted regardless of enable or state, since zero_cross latency trails fir_en.
- in_valid with in_ready=0: no effect. The source must hold its data; data is never dropped.
- Reset mid-burst: the remaining stuffing strobes are abandoned, the partial frame is discarded, and zc_count=0.

Decomposition:
- Package interp_pkg:
  - constants L, DW, FRAC, FRAME, CW;
  - state encoding enum {IDLE, PUSH, STUFF};
  - derived phase width clog2(L) and frame-counter width clog2(FRAME).
- One sub-module, zc_frame_counter, holds the frame counter, crossing accumulator, saturation, zc_count latch and frame_done.
  - Inputs: clk, reset, fir_en, zc_flag.
- The FSM and handshake stay in interp_sched.

Test Plan:
1. L=8, single in_data=32'h0000_0003 at cycle 5:
   - fir_en high cycles 6..13;
   - fir_data=48'h0000_0003_0000 at cycle 6, then 0 for cycles 7..13;
   - in_ready low cycles 6..12, high at 13.
2. in_valid held high, L=8: samples accepted at cycles 0, 8, 16, 24; fir_en continuously high from cycle 1; exactly 4 PUSH cycles in 32.
3. FRAME=256, L=8, 32 samples, zc_flag pulsed 7 times inside the frame:
   - frame_done pulses once, one cycle after the 256th fir_en;
   - zc_count=7.
4. zc_flag on the final fir_en cycle and again on the frame_done cycle: zc_count includes the first (+1); the next frame's accumulator starts at 1.
5. zc_flag held high 600 cycles with CW=9: zc_count saturates at 511, no wrap.
6. enable dropped at the second strobe of a burst: all 8 strobes complete, in_ready stays 0. Then reset asserted mid-next-burst: fir_en=0 and zc_count=0 the following cycle.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the interpolator sequencing controller.
package interp_pkg;
  localparam int L     = 8;    // interpolation factor
  localparam int DW    = 32;   // input sample width
  localparam int FRAC  = 16;   // zero fraction bits appended on fir_data
  localparam int FRAME = 256;  // fir_en strobes per measurement window
  localparam int CW    = 9;    // crossing counter width

  // Phase counter must stay at least one bit wide even when L == 1.
  localparam int PW  = (L > 1) ? $clog2(L) : 1;
  localparam int FCW = $clog2(FRAME);

  localparam logic [PW-1:0] PH_LAST = PW'(L - 1);

  typedef enum logic [1:0] {IDLE, PUSH, STUFF} state_e;
endpackage

// File: rtl/zc_frame_counter.sv
// Frames fir_en strobes into FRAME-long windows and reports the saturating
// zero-crossing count of each completed window.
module zc_frame_counter
  import interp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          fir_en,
  input  logic          zc_flag,
  output logic          frame_done,
  output logic [CW-1:0] zc_count
);
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0]  acc_q, acc_d, acc_inc;
  logic [CW-1:0]  zc_q, zc_d;
  logic           done_q, done_d;

  // Next-state: the closing strobe latches the count including its own zc_flag.
  always_comb begin
    acc_inc = (zc_flag && (acc_q != '1)) ? acc_q + CW'(1) : acc_q;
    fcnt_d  = fcnt_q;
    acc_d   = acc_inc;
    zc_d    = zc_q;
    done_d  = 1'b0;
    if (fir_en) begin
      if (fcnt_q == FCW'(FRAME - 1)) begin
        fcnt_d = '0;
        zc_d   = acc_inc;
        acc_d  = '0;
        done_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FCW'(1);
      end
    end
  end

  // Frame state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
      acc_q  <= '0;
      zc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      acc_q  <= acc_d;
      zc_q   <= zc_d;
      done_q <= done_d;
    end
  end

  assign frame_done = done_q;
  assign zc_count   = zc_q;
endmodule

// File: rtl/interp_sched.sv
// Zero-stuffing sequencer feeding firQ at L times the input rate, plus
// per-window zero-crossing reporting.
module interp_sched
  import interp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_data,
  output logic               in_ready,
  output logic               fir_en,
  output logic [DW+FRAC-1:0] fir_data,
  input  logic               zc_flag,
  output logic               frame_done,
  output logic [CW-1:0]      zc_count
);
  state_e             state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [DW-1:0]      sample_q, sample_d;
  logic [DW+FRAC-1:0] hold_q;
  logic               last_ph, accept;

  // Handshake, burst sequencing and filter-side outputs.
  always_comb begin
    last_ph  = (phase_q == PH_LAST);
    in_ready = !reset && enable &&
               ((state_q == IDLE) || ((state_q == STUFF) && last_ph) ||
                ((L == 1) && (state_q == PUSH)));
    accept   = in_valid && in_ready;
    state_d  = state_q;
    phase_d  = phase_q;
    sample_d = accept ? in_data : sample_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PUSH;
          phase_d = '0;
        end
      end
      PUSH: begin
        if (L == 1) begin
          state_d = accept ? PUSH : IDLE;
        end else begin
          state_d = STUFF;
          phase_d = PW'(1);
        end
      end
      STUFF: begin
        if (last_ph) begin
          state_d = accept ? PUSH : IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced quiet while reset is held; fir_data keeps its
    // last strobed value between bursts.
    fir_en   = !reset && (state_q != IDLE);
    fir_data = hold_q;
    if (reset)                 fir_data = '0;
    else if (state_q == PUSH)  fir_data = {sample_q, {FRAC{1'b0}}};
    else if (state_q == STUFF) fir_data = '0;
  end

  // FSM, sample and fir_data hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      sample_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      if (fir_en) hold_q <= fir_data;
    end
  end

  zc_frame_counter u_frame (
    .clk        (clk),
    .reset      (reset),
    .fir_en     (fir_en),
    .zc_flag    (zc_flag),
    .frame_done (frame_done),
    .zc_count   (zc_count)
  );
endmodule
